// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external RAM with one-port-per-cycle arbitration.
// Optional sticky overflow/underflow flags: define RAM_FIFO_CTRL_ERR_FLAGS_EN.
module ram_fifo_ctrl #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 8,
   parameter int AFULL_THR = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   output logic              push_ack,
   input  logic              pop,
   output logic              pop_ack,
   output logic              pop_valid,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   count,
   output logic              ram_we,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_wr_addr,
   output logic [ADDR_W-1:0] ram_rd_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
   ,
   output logic              ovf_err,
   output logic              unf_err
`endif
);

   localparam logic [ADDR_W:0] C_FULL  = (ADDR_W+1)'(1 << ADDR_W);
   localparam logic [ADDR_W:0] C_AFULL = (ADDR_W+1)'(AFULL_THR);

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_prio;
   logic              r_pop_valid;

   logic w_push_el;
   logic w_pop_el;
   logic w_both;
   logic w_push_gnt;
   logic w_pop_gnt;

   assign full        = (r_count == C_FULL);
   assign empty       = (r_count == '0);
   assign almost_full = (r_count >= C_AFULL);
   assign count       = r_count;

   assign w_push_el = push & ~full;
   assign w_pop_el  = pop & ~empty;
   assign w_both    = w_push_el & w_pop_el;

   // Arbitrate the single RAM port; alternate on contention, idle in reset
   always_comb begin
      w_push_gnt = 1'b0;
      w_pop_gnt  = 1'b0;
      if (!rst) begin
         if (w_both) begin
            w_push_gnt = ~r_prio;
            w_pop_gnt  = r_prio;
         end else begin
            w_push_gnt = w_push_el;
            w_pop_gnt  = w_pop_el;
         end
      end
   end

   assign push_ack    = w_push_gnt;
   assign pop_ack     = w_pop_gnt;
   assign ram_we      = w_push_gnt;
   assign ram_re      = w_pop_gnt;
   assign ram_wr_addr = r_wr_ptr;
   assign ram_rd_addr = r_rd_ptr;
   assign ram_wdata   = push_data;
   assign pop_valid   = r_pop_valid;
   assign pop_data    = ram_rdata;

   // Pointers, occupancy, priority and read-valid pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_prio      <= 1'b0;
         r_pop_valid <= 1'b0;
      end else begin
         if (w_push_gnt) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            r_count  <= r_count + (ADDR_W+1)'(1);
         end
         if (w_pop_gnt) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_count  <= r_count - (ADDR_W+1)'(1);
         end
         if (w_both) begin
            r_prio <= ~r_prio;
         end
         r_pop_valid <= w_pop_gnt;
      end
   end

`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
   // Sticky flags for requests rejected by a full or empty FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         if (push && full) begin
            ovf_err <= 1'b1;
         end
         if (pop && empty) begin
            unf_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: RAM model, reference model and data scoreboard.
// Build with RAM_FIFO_CTRL_ERR_FLAGS_EN to also cover the error flags.
module tb_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       push = 1'b0;
   logic [7:0] push_data = '0;
   logic       push_ack;
   logic       pop = 1'b0;
   logic       pop_ack;
   logic       pop_valid;
   logic [7:0] pop_data;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic [4:0] count;
   logic       ram_we;
   logic       ram_re;
   logic [3:0] ram_wr_addr;
   logic [3:0] ram_rd_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata = '0;
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
   logic       ovf_err;
   logic       unf_err;
`endif

   int n_chk = 0;
   int n_err = 0;
   logic mon_en = 1'b0;

   ram_fifo_ctrl #(.ADDR_W(4), .DATA_W(8), .AFULL_THR(12)) dut (
      .clk(clk),
      .rst(rst),
      .push(push),
      .push_data(push_data),
      .push_ack(push_ack),
      .pop(pop),
      .pop_ack(pop_ack),
      .pop_valid(pop_valid),
      .pop_data(pop_data),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .count(count),
      .ram_we(ram_we),
      .ram_re(ram_re),
      .ram_wr_addr(ram_wr_addr),
      .ram_rd_addr(ram_rd_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
      ,
      .ovf_err(ovf_err),
      .unf_err(unf_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp,
                  $time);
      end
   endtask

   // Synchronous RAM with registered read data
   logic [7:0] mem [16];
   always @(posedge clk) begin
      if (ram_we) mem[ram_wr_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= mem[ram_rd_addr];
   end

   // Reference model state
   logic [7:0] model_q[$];
   logic [7:0] exp_q[$];
   logic [3:0] m_wr = '0;
   logic [3:0] m_rd = '0;
   logic       m_prio = 1'b0;
   logic       m_pv = 1'b0;
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;
   int         sz;
   logic       ep, eq, gp, gq;

   // Compare every cycle against the model, then advance the model
   always @(negedge clk) begin
      if (mon_en) begin
         sz = model_q.size();
         chk("count", 32'(count), 32'(sz));
         chk("empty", 32'(empty), 32'(sz == 0));
         chk("full", 32'(full), 32'(sz == 16));
         chk("afull", 32'(almost_full), 32'(sz >= 12));
         chk("wr_addr", 32'(ram_wr_addr), 32'(m_wr));
         chk("rd_addr", 32'(ram_rd_addr), 32'(m_rd));
         chk("wdata", 32'(ram_wdata), 32'(push_data));
         ep = push && (sz < 16);
         eq = pop && (sz > 0);
         gp = 1'b0;
         gq = 1'b0;
         if (!rst) begin
            if (ep && eq) begin
               gp = !m_prio;
               gq = m_prio;
            end else begin
               gp = ep;
               gq = eq;
            end
         end
         chk("push_ack", 32'(push_ack), 32'(gp));
         chk("pop_ack", 32'(pop_ack), 32'(gq));
         chk("ram_we", 32'(ram_we), 32'(gp));
         chk("ram_re", 32'(ram_re), 32'(gq));
         chk("we_re_excl", 32'(ram_we & ram_re), 32'(0));
         chk("pop_valid", 32'(pop_valid), 32'(m_pv));
         if (pop_valid && exp_q.size() > 0)
            chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
         chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
         chk("unf_err", 32'(unf_err), 32'(m_unf));
`endif
         if (rst) begin
            model_q.delete();
            exp_q.delete();
            m_wr = '0;
            m_rd = '0;
            m_prio = 1'b0;
            m_pv = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end else begin
            if (gp) begin
               model_q.push_back(push_data);
               m_wr = m_wr + 4'd1;
            end
            if (gq) begin
               exp_q.push_back(model_q.pop_front());
               m_rd = m_rd + 4'd1;
            end
            if (ep && eq) m_prio = !m_prio;
            m_pv = gq;
            if (push && sz == 16) m_ovf = 1'b1;
            if (pop && sz == 0) m_unf = 1'b1;
         end
      end
   end

   // One cycle: drive just after the edge, return at the falling edge
   task automatic cyc(input logic r, input logic p, input logic [7:0] d,
                      input logic q);
      @(posedge clk);
      #1;
      rst = r;
      push = p;
      push_data = d;
      pop = q;
      @(negedge clk);
   endtask

   initial begin
      @(posedge clk);
      mon_en = 1'b1;

      // Reset: acks held low even with requests pending
      cyc(1'b1, 1'b1, 8'h55, 1'b1);
      chk("rst_push_ack", 32'(push_ack), 32'(0));
      chk("rst_ram_we", 32'(ram_we), 32'(0));
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("rst_count", 32'(count), 32'(0));
      chk("rst_empty", 32'(empty), 32'(1));
      chk("rst_pv", 32'(pop_valid), 32'(0));

      // Basic ordering A1..A4
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'hA1 + 8'(i), 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("basic_pv_last", 32'(pop_valid), 32'(1));
      chk("basic_data_last", 32'(pop_data), 32'(8'hA4));
      chk("basic_empty", 32'(empty), 32'(1));

      // Fill to full, then overflow attempt
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
         if (i == 11) chk("afull_11", 32'(almost_full), 32'(0));
         if (i == 12) chk("afull_12", 32'(almost_full), 32'(1));
      end
      cyc(1'b0, 1'b1, 8'hEE, 1'b0);
      chk("ovf_ack", 32'(push_ack), 32'(0));
      chk("ovf_full", 32'(full), 32'(1));
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("ovf_count", 32'(count), 32'(16));
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
      chk("ovf_flag", 32'(ovf_err), 32'(1));
`endif

      // Down to 5, then contention alternates grants
      for (int i = 0; i < 11; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 1'b1, 8'hC0 + 8'(k), 1'b1);
         chk("alt_push", 32'(push_ack), 32'(k % 2 == 0));
         chk("alt_pop", 32'(pop_ack), 32'(k % 2 == 1));
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("alt_count", 32'(count), 32'(5));
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);

      // Wrap: 20 push/pop pairs from fresh pointers
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0);
         cyc(1'b0, 1'b0, 8'h00, 1'b1);
         if (i == 15) chk("wr_wrap", 32'(ram_wr_addr), 32'(0));
      end
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("wrap_last", 32'(pop_data), 32'(8'h43));

      // Underflow
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("unf_ack", 32'(pop_ack), 32'(0));
      chk("unf_re", 32'(ram_re), 32'(0));
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef RAM_FIFO_CTRL_ERR_FLAGS_EN
      chk("unf_flag", 32'(unf_err), 32'(1));
`endif

      // Reset right after a pop grant
      cyc(1'b0, 1'b1, 8'h71, 1'b0);
      cyc(1'b0, 1'b1, 8'h72, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
      chk("rr_pop_ack", 32'(pop_ack), 32'(1));
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("rr_pv", 32'(pop_valid), 32'(0));
      chk("rr_count", 32'(count), 32'(0));
      chk("rr_empty", 32'(empty), 32'(1));

      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("sb_drain", 32'(exp_q.size()), 32'(0));
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
